ctx_wrq_fifo: RTL and testbench
===============================

CTX_WRQ_FIFO -- requirements
Module: ctx_wrq_fifo

Interface
REQ-001 Parameter DEPTH, 8, FIFO entry count; SHALL be a power of two, 2..32.
REQ-002 Port clkin  in  1  single clock; all state SHALL change on its rising edge.
REQ-003 Port reset_n  in  1  asynchronous, active-low reset.
REQ-004 Port WRQ_IN  in  1  one-cycle write-request pulse from the context-capture stage.
REQ-005 Port ADDR_IN  in  24  SRAM address qualified by WRQ_IN.
REQ-006 Port DATA_IN  in  8  write data qualified by WRQ_IN.
REQ-007 Port FLUSH  in  1  synchronous discard of all queued entries.
REQ-008 Port BUS_RDY  in  1  memory arbiter idle/done indication.
REQ-009 Port BUS_WRQ  out  1  one-cycle write-request pulse to the memory arbiter.
REQ-010 Port ROM_ADDR  out  24  address of the head entry in flight.
REQ-011 Port ROM_DATA  out  8  data of the head entry in flight.
REQ-012 Port LEVEL  out  6  current entry count, 0..DEPTH.
REQ-013 Port OVF  out  1  sticky overflow flag.
REQ-014 Port DROP_CNT  out  8  saturating count of dropped requests.

Function
REQ-015 Storage SHALL be a DEPTH-entry circular buffer of {ADDR_IN, DATA_IN} with wrapping read and write pointers.
REQ-016 Push: WRQ_IN high and not full SHALL write the entry at the write pointer and advance it (mod DEPTH).
REQ-017 Push while full SHALL be dropped, set OVF, and increment DROP_CNT, saturating at 255.
REQ-018 A push in the same cycle as a pop while full SHALL be accepted; LEVEL SHALL stay DEPTH.
REQ-019 A push and a pop in the same cycle at any level SHALL leave LEVEL unchanged.
REQ-020 FSM states SHALL be IDLE, ISSUE, WAIT_ACK, WAIT_DONE.
REQ-021 IDLE -> ISSUE when LEVEL != 0 and BUS_RDY = 1; ROM_ADDR/ROM_DATA SHALL load the head entry on that edge.
REQ-022 ISSUE SHALL last exactly one cycle with BUS_WRQ = 1, then go to WAIT_ACK; BUS_WRQ SHALL be 0 in every other state.
REQ-023 WAIT_ACK -> WAIT_DONE on the first cycle BUS_RDY = 0 (arbiter accepted).
REQ-024 WAIT_DONE -> IDLE on the first cycle BUS_RDY = 1; that edge SHALL pop the head entry (advance read pointer, LEVEL - 1).
REQ-025 ROM_ADDR/ROM_DATA SHALL remain stable from ISSUE through WAIT_DONE.
REQ-026 Minimum spacing between BUS_WRQ pulses SHALL be 4 cycles.
REQ-027 Write order SHALL equal push order; no entry SHALL be issued twice or skipped.
REQ-028 FLUSH in IDLE SHALL zero both pointers and LEVEL on the next edge; a same-cycle WRQ_IN SHALL be discarded without counting as a drop.
REQ-029 FLUSH outside IDLE SHALL let the in-flight entry complete and pop, then discard the remainder on the return to IDLE.
REQ-030 FLUSH SHALL NOT clear OVF or DROP_CNT.
REQ-031 LEVEL SHALL be a registered output derived from the pointers and SHALL never exceed DEPTH.

Reset
REQ-032 reset_n low SHALL immediately force: FSM = IDLE; pointers = 0; LEVEL = 0; BUS_WRQ = 0; ROM_ADDR = 24'h000000; ROM_DATA = 8'h00; OVF = 0; DROP_CNT = 0.
REQ-033 Reset asserted mid-transaction SHALL abandon the in-flight entry with no further BUS_WRQ pulse.
REQ-034 Operation SHALL resume on the first rising edge after reset_n is released.

Verification
REQ-035 Single push (ADDR_IN = 24'hF50123, DATA_IN = 8'hA5), BUS_RDY = 1 -> one BUS_WRQ pulse 2 cycles later with ROM_ADDR = F50123 and ROM_DATA = A5; pop after BUS_RDY goes 0 then 1; LEVEL returns to 0.
REQ-036 Ten back-to-back pushes, BUS_RDY held 0, DEPTH = 8 -> LEVEL = 8, OVF = 1, DROP_CNT = 2; after BUS_RDY is released the first 8 entries are written in order.
REQ-037 Full FIFO with push coinciding with the WAIT_DONE pop -> push accepted, LEVEL stays 8, DROP_CNT unchanged.
REQ-038 Pointer wrap: 20 push/complete cycles at DEPTH = 8 -> all 20 entries issued in order, LEVEL = 0 at end.
REQ-039 FLUSH in WAIT_ACK with 3 entries queued -> the in-flight entry completes, then LEVEL = 0 and no further BUS_WRQ pulses.
REQ-040 reset_n pulsed low in WAIT_DONE -> outputs at reset values immediately; no pop, no BUS_WRQ pulse afterwards.

Source files
------------

// File: rtl/ctx_wrq_fifo.sv
// ctx_wrq_fifo: queues context-capture write requests ({address, data}) in a
// circular buffer and issues them one at a time to the memory arbiter using a
// four-state request/acknowledge/done handshake.
module ctx_wrq_fifo #(
   parameter int DEPTH = 8
) (
   input  logic        clkin,
   input  logic        reset_n,
   input  logic        WRQ_IN,
   input  logic [23:0] ADDR_IN,
   input  logic [7:0]  DATA_IN,
   input  logic        FLUSH,
   input  logic        BUS_RDY,
   output logic        BUS_WRQ,
   output logic [23:0] ROM_ADDR,
   output logic [7:0]  ROM_DATA,
   output logic [5:0]  LEVEL,
   output logic        OVF,
   output logic [7:0]  DROP_CNT
);

   // Pointers carry one extra wrap bit so that full and empty are distinguishable
   // and the occupancy is simply their difference.
   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;
   localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);

   if (DEPTH < 2 || DEPTH > 32 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_chk
      $error("ctx_wrq_fifo: DEPTH must be a power of two in 2..32");
   end

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      ISSUE     = 2'd1,
      WAIT_ACK  = 2'd2,
      WAIT_DONE = 2'd3
   } state_t;

   state_t          state_q, state_d;
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]   level_q, level_d;
   logic [23:0]     rom_addr_q, rom_addr_d;
   logic [7:0]      rom_data_q, rom_data_d;
   logic            ovf_q, ovf_d;
   logic [7:0]      drop_q, drop_d;
   logic            flush_pend_q, flush_pend_d;
   logic [31:0]     mem_q [DEPTH];

   logic            bus_wrq;
   logic            pop;
   logic            push;
   logic            drop;
   logic            full;
   logic            idle_flush;
   logic            discard;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   // Issue FSM: picks up the head entry, pulses the request, waits for the
   // arbiter to go busy and then idle again, and pops the entry on completion.
   always_comb begin
      state_d    = state_q;
      rom_addr_d = rom_addr_q;
      rom_data_d = rom_data_q;
      bus_wrq    = 1'b0;
      pop        = 1'b0;
      case (state_q)
         IDLE: begin
            // A flush in IDLE empties the queue on this edge, so nothing is issued.
            if (!FLUSH && level_q != '0 && BUS_RDY) begin
               state_d                  = ISSUE;
               {rom_addr_d, rom_data_d} = mem_q[rd_ptr_q[AW-1:0]];
            end
         end
         ISSUE: begin
            bus_wrq = 1'b1;
            state_d = WAIT_ACK;
         end
         WAIT_ACK: begin
            if (!BUS_RDY) state_d = WAIT_DONE;
         end
         WAIT_DONE: begin
            if (BUS_RDY) begin
               state_d = IDLE;
               pop     = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Queue bookkeeping: push/drop decisions, flush handling and next occupancy.
   always_comb begin
      full         = (level_q == DEPTH_P);
      idle_flush   = (state_q == IDLE) && FLUSH;
      // A flush seen while a transfer was in flight takes effect with its pop.
      discard      = pop && (flush_pend_q || FLUSH);
      // When full, a simultaneous pop frees the slot the push lands in.
      push         = WRQ_IN && (!full || pop) && !idle_flush;
      drop         = WRQ_IN && full && !pop && !idle_flush;
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      flush_pend_d = flush_pend_q;
      ovf_d        = ovf_q;
      drop_d       = drop_q;
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      if (drop) begin
         ovf_d  = 1'b1;
         drop_d = sat_inc8(drop_q);
      end
      if (FLUSH && state_q != IDLE) flush_pend_d = 1'b1;
      if (idle_flush || discard) begin
         wr_ptr_d     = '0;
         rd_ptr_d     = '0;
         flush_pend_d = 1'b0;
      end
      level_d = wr_ptr_d - rd_ptr_d;
   end

   // Entry storage; contents need no reset because occupancy gates every read.
   always_ff @(posedge clkin) begin
      if (push) mem_q[wr_ptr_q[AW-1:0]] <= {ADDR_IN, DATA_IN};
   end

   // Control and output registers with asynchronous reset.
   always_ff @(posedge clkin or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         level_q      <= '0;
         rom_addr_q   <= 24'h000000;
         rom_data_q   <= 8'h00;
         ovf_q        <= 1'b0;
         drop_q       <= 8'h00;
         flush_pend_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         level_q      <= level_d;
         rom_addr_q   <= rom_addr_d;
         rom_data_q   <= rom_data_d;
         ovf_q        <= ovf_d;
         drop_q       <= drop_d;
         flush_pend_q <= flush_pend_d;
      end
   end

   assign BUS_WRQ  = bus_wrq;
   assign ROM_ADDR = rom_addr_q;
   assign ROM_DATA = rom_data_q;
   assign LEVEL    = 6'(level_q);
   assign OVF      = ovf_q;
   assign DROP_CNT = drop_q;

endmodule

// File: tb/tb_ctx_wrq_fifo.sv
// tb_ctx_wrq_fifo: directed and randomized checks of ctx_wrq_fifo against a
// queue-based reference model of the write-request queue.
module tb_ctx_wrq_fifo;

   localparam int DEPTH = 8;

   logic        clk = 1'b0;
   logic        reset_n = 1'b1;
   logic        WRQ_IN = 1'b0;
   logic [23:0] ADDR_IN = '0;
   logic [7:0]  DATA_IN = '0;
   logic        FLUSH = 1'b0;
   logic        BUS_RDY = 1'b0;
   logic        BUS_WRQ;
   logic [23:0] ROM_ADDR;
   logic [7:0]  ROM_DATA;
   logic [5:0]  LEVEL;
   logic        OVF;
   logic [7:0]  DROP_CNT;

   int n_assert = 0;
   int n_fail = 0;

   // reference model state
   logic [31:0] mq[$];
   logic [31:0] got_q[$];
   logic [31:0] exp_q[$];
   bit          m_inflight, m_seen_low, m_expect, m_ovf, m_flush_pend;
   int          m_drop, m_unexp, m_missed, m_romchg;
   logic [31:0] m_hold;

   // automatic arbiter state
   bit arb_auto, arb_busy;
   int arb_lo;

   ctx_wrq_fifo #(.DEPTH(DEPTH)) dut (
      .clkin   (clk),
      .reset_n (reset_n),
      .WRQ_IN  (WRQ_IN),
      .ADDR_IN (ADDR_IN),
      .DATA_IN (DATA_IN),
      .FLUSH   (FLUSH),
      .BUS_RDY (BUS_RDY),
      .BUS_WRQ (BUS_WRQ),
      .ROM_ADDR(ROM_ADDR),
      .ROM_DATA(ROM_DATA),
      .LEVEL   (LEVEL),
      .OVF     (OVF),
      .DROP_CNT(DROP_CNT)
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      mq.delete();
      got_q.delete();
      exp_q.delete();
      m_inflight = 0; m_seen_low = 0; m_expect = 0; m_ovf = 0; m_flush_pend = 0;
      m_drop = 0; m_unexp = 0; m_missed = 0; m_romchg = 0; m_hold = '0;
      arb_busy = 0; arb_lo = 0;
   endtask

   // Advance the model across the coming clock edge using the inputs about to
   // be sampled and the outputs visible during the current cycle.
   task automatic model_update();
      bit idle, pop;
      if (!reset_n) begin
         model_reset();
         return;
      end
      if ((BUS_WRQ === 1'b1) != m_expect) begin
         if (BUS_WRQ === 1'b1) m_unexp++;
         else m_missed++;
      end
      if (BUS_WRQ === 1'b1) begin
         got_q.push_back({ROM_ADDR, ROM_DATA});
         if (mq.size() > 0) exp_q.push_back(mq[0]);
         else m_unexp++;
         m_hold = {ROM_ADDR, ROM_DATA};
      end
      if (m_inflight && {ROM_ADDR, ROM_DATA} !== m_hold) m_romchg++;
      idle     = !m_inflight && (BUS_WRQ !== 1'b1);
      m_expect = idle && !FLUSH && mq.size() > 0 && BUS_RDY;
      pop      = m_inflight && m_seen_low && BUS_RDY;
      if (FLUSH && !idle) m_flush_pend = 1;
      if (pop) void'(mq.pop_front());
      if (WRQ_IN && !(FLUSH && idle)) begin
         if (mq.size() < DEPTH) mq.push_back({ADDR_IN, DATA_IN});
         else begin
            m_ovf = 1;
            if (m_drop < 255) m_drop++;
         end
      end
      if (FLUSH && idle) begin mq.delete(); m_flush_pend = 0; end
      if (pop && m_flush_pend) begin mq.delete(); m_flush_pend = 0; end
      if (pop) begin m_inflight = 0; m_seen_low = 0; end
      else if (m_inflight && !BUS_RDY) m_seen_low = 1;
      if (BUS_WRQ === 1'b1) begin m_inflight = 1; m_seen_low = 0; end
   endtask

   // One clock cycle: optional arbiter behaviour, model update, then the edge.
   task automatic step();
      if (arb_auto) begin
         if (BUS_WRQ === 1'b1) begin
            arb_busy = 1;
            arb_lo   = 2 + $urandom_range(0, 2);
         end
         if (arb_busy) begin
            if (arb_lo > 0) begin BUS_RDY = 1'b0; arb_lo--; end
            else begin BUS_RDY = 1'b1; arb_busy = 0; end
         end else begin
            BUS_RDY = ($urandom_range(0, 3) != 0);
         end
      end
      model_update();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [23:0] a, input logic [7:0] d);
      WRQ_IN  = 1'b1;
      ADDR_IN = a;
      DATA_IN = d;
      step();
      WRQ_IN  = 1'b0;
   endtask

   task automatic do_reset();
      WRQ_IN = 0; FLUSH = 0; BUS_RDY = 0; arb_auto = 0;
      reset_n = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;
   endtask

   task automatic drain(input int bound, output bit ok);
      WRQ_IN = 0; FLUSH = 0; arb_auto = 1; ok = 0;
      for (int i = 0; i < bound; i++) begin
         if (mq.size() == 0 && !m_inflight && BUS_WRQ !== 1'b1) begin
            ok = 1;
            break;
         end
         step();
      end
      arb_auto = 0;
   endtask

   task automatic test_reset();
      #2 reset_n = 1'b0;
      model_reset();
      #1;
      n_assert++;
      if (BUS_WRQ !== 1'b0 || LEVEL !== 6'd0 || OVF !== 1'b0 || DROP_CNT !== 8'd0) begin
         n_fail++;
         $display("FAIL reset_ctrl: BUS_WRQ=%b LEVEL=%0d OVF=%b DROP=%0d required 0/0/0/0", BUS_WRQ, LEVEL, OVF, DROP_CNT);
      end
      n_assert++;
      if (ROM_ADDR !== 24'h000000 || ROM_DATA !== 8'h00) begin
         n_fail++;
         $display("FAIL reset_rom: ROM=%h/%h required 000000/00", ROM_ADDR, ROM_DATA);
      end
      @(posedge clk);
      #1;
      reset_n = 1'b1;
   endtask

   task automatic test_single_push();
      do_reset();
      BUS_RDY = 1'b1;
      push(24'hF50123, 8'hA5);
      n_assert++;
      if (LEVEL !== 6'd1 || BUS_WRQ !== 1'b0) begin
         n_fail++;
         $display("FAIL single_after_push: LEVEL=%0d BUS_WRQ=%b required 1/0", LEVEL, BUS_WRQ);
      end
      step();
      n_assert++;
      if (BUS_WRQ !== 1'b1 || ROM_ADDR !== 24'hF50123 || ROM_DATA !== 8'hA5) begin
         n_fail++;
         $display("FAIL single_issue: BUS_WRQ=%b ROM=%h/%h required 1 F50123/A5", BUS_WRQ, ROM_ADDR, ROM_DATA);
      end
      step();
      n_assert++;
      if (BUS_WRQ !== 1'b0) begin
         n_fail++;
         $display("FAIL single_pulse_width: BUS_WRQ=%b required 0", BUS_WRQ);
      end
      BUS_RDY = 1'b0;
      step();
      n_assert++;
      if (LEVEL !== 6'd1 || ROM_ADDR !== 24'hF50123 || ROM_DATA !== 8'hA5) begin
         n_fail++;
         $display("FAIL single_wait_done: LEVEL=%0d ROM=%h/%h required 1 F50123/A5", LEVEL, ROM_ADDR, ROM_DATA);
      end
      BUS_RDY = 1'b1;
      step();
      n_assert++;
      if (LEVEL !== 6'd0 || BUS_WRQ !== 1'b0) begin
         n_fail++;
         $display("FAIL single_pop: LEVEL=%0d BUS_WRQ=%b required 0/0", LEVEL, BUS_WRQ);
      end
   endtask

   task automatic test_overflow();
      bit ok;
      logic [31:0] e;
      do_reset();
      BUS_RDY = 1'b0;
      for (int i = 0; i < 10; i++) push(24'(24'h100000 + i), 8'(i));
      n_assert++;
      if (LEVEL !== 6'd8 || OVF !== 1'b1 || DROP_CNT !== 8'd2) begin
         n_fail++;
         $display("FAIL overflow_state: LEVEL=%0d OVF=%b DROP=%0d required 8/1/2", LEVEL, OVF, DROP_CNT);
      end
      drain(300, ok);
      n_assert++;
      if (!ok || LEVEL !== 6'd0 || got_q.size() != 8 || m_unexp != 0 || m_missed != 0 || m_romchg != 0) begin
         n_fail++;
         $display("FAIL overflow_drain: done=%0d LEVEL=%0d issued=%0d unexp=%0d missed=%0d romchg=%0d required 1/0/8/0/0/0",
                  ok, LEVEL, got_q.size(), m_unexp, m_missed, m_romchg);
      end
      for (int i = 0; i < got_q.size() && i < 8; i++) begin
         e = {24'(24'h100000 + i), 8'(i)};
         n_assert++;
         if (got_q[i] !== e) begin
            n_fail++;
            $display("FAIL overflow_order[%0d]: issued %h required %h", i, got_q[i], e);
         end
      end
   endtask

   task automatic test_full_push_pop();
      bit ok;
      do_reset();
      BUS_RDY = 1'b0;
      for (int i = 0; i < 8; i++) push(24'(24'h200000 + i), 8'(8'h10 + i));
      BUS_RDY = 1'b1;
      step();
      n_assert++;
      if (BUS_WRQ !== 1'b1 || LEVEL !== 6'd8) begin
         n_fail++;
         $display("FAIL full_issue: BUS_WRQ=%b LEVEL=%0d required 1/8", BUS_WRQ, LEVEL);
      end
      step();
      BUS_RDY = 1'b0;
      step();
      BUS_RDY = 1'b1;
      push(24'h2000AA, 8'h5A);
      n_assert++;
      if (LEVEL !== 6'd8 || DROP_CNT !== 8'd0 || OVF !== 1'b0) begin
         n_fail++;
         $display("FAIL full_push_pop: LEVEL=%0d DROP=%0d OVF=%b required 8/0/0", LEVEL, DROP_CNT, OVF);
      end
      drain(300, ok);
      n_assert++;
      if (!ok || got_q.size() != 9 || m_unexp != 0 || m_missed != 0) begin
         n_fail++;
         $display("FAIL full_drain: done=%0d issued=%0d unexp=%0d missed=%0d required 1/9/0/0", ok, got_q.size(), m_unexp, m_missed);
      end else begin
         n_assert++;
         if (got_q[8] !== 32'h2000AA5A || got_q[1] !== 32'h20000111) begin
            n_fail++;
            $display("FAIL full_order: issued[1]=%h issued[8]=%h required 20000111/2000AA5A", got_q[1], got_q[8]);
         end
      end
   endtask

   task automatic test_wrap();
      bit ok, all_ok;
      logic [31:0] e;
      do_reset();
      all_ok = 1;
      for (int k = 0; k < 20; k++) begin
         BUS_RDY = 1'b0;
         push(24'(24'h300000 + k), 8'(k));
         drain(60, ok);
         all_ok = all_ok && ok;
      end
      n_assert++;
      if (!all_ok || LEVEL !== 6'd0 || got_q.size() != 20 || m_unexp != 0 || m_missed != 0) begin
         n_fail++;
         $display("FAIL wrap_summary: done=%0d LEVEL=%0d issued=%0d unexp=%0d missed=%0d required 1/0/20/0/0",
                  all_ok, LEVEL, got_q.size(), m_unexp, m_missed);
      end
      for (int i = 0; i < got_q.size() && i < 20; i++) begin
         e = {24'(24'h300000 + i), 8'(i)};
         n_assert++;
         if (got_q[i] !== e) begin
            n_fail++;
            $display("FAIL wrap_order[%0d]: issued %h required %h", i, got_q[i], e);
         end
      end
   endtask

   task automatic test_flush_wait_ack();
      int pulses;
      do_reset();
      BUS_RDY = 1'b0;
      for (int i = 0; i < 3; i++) push(24'(24'h400000 + i), 8'(i));
      BUS_RDY = 1'b1;
      step();
      n_assert++;
      if (BUS_WRQ !== 1'b1 || ROM_ADDR !== 24'h400000) begin
         n_fail++;
         $display("FAIL flush_issue: BUS_WRQ=%b ROM_ADDR=%h required 1/400000", BUS_WRQ, ROM_ADDR);
      end
      step();
      FLUSH = 1'b1;
      step();
      FLUSH = 1'b0;
      BUS_RDY = 1'b0;
      step();
      n_assert++;
      if (LEVEL !== 6'd3) begin
         n_fail++;
         $display("FAIL flush_in_flight: LEVEL=%0d required 3", LEVEL);
      end
      BUS_RDY = 1'b1;
      step();
      n_assert++;
      if (LEVEL !== 6'd0) begin
         n_fail++;
         $display("FAIL flush_discard: LEVEL=%0d required 0", LEVEL);
      end
      pulses = 0;
      for (int i = 0; i < 12; i++) begin
         step();
         if (BUS_WRQ === 1'b1) pulses++;
      end
      n_assert++;
      if (pulses != 0 || LEVEL !== 6'd0) begin
         n_fail++;
         $display("FAIL flush_quiet: pulses=%0d LEVEL=%0d required 0/0", pulses, LEVEL);
      end
   endtask

   task automatic test_flush_idle();
      bit ok;
      do_reset();
      BUS_RDY = 1'b0;
      for (int i = 0; i < 9; i++) push(24'(24'h500000 + i), 8'(i));
      FLUSH = 1'b1;
      push(24'h5000FF, 8'hFF);
      FLUSH = 1'b0;
      n_assert++;
      if (LEVEL !== 6'd0 || DROP_CNT !== 8'd1 || OVF !== 1'b1) begin
         n_fail++;
         $display("FAIL flush_idle: LEVEL=%0d DROP=%0d OVF=%b required 0/1/1", LEVEL, DROP_CNT, OVF);
      end
      push(24'h5000EE, 8'hEE);
      n_assert++;
      if (LEVEL !== 6'd1) begin
         n_fail++;
         $display("FAIL flush_idle_refill: LEVEL=%0d required 1", LEVEL);
      end
      drain(60, ok);
      n_assert++;
      if (!ok || got_q.size() != 1 || (got_q.size() == 1 && got_q[0] !== 32'h5000EEEE)) begin
         n_fail++;
         $display("FAIL flush_idle_issue: done=%0d issued=%0d required 1/1 entry 5000EEEE", ok, got_q.size());
      end
   endtask

   task automatic test_drop_sat();
      do_reset();
      BUS_RDY = 1'b0;
      WRQ_IN  = 1'b1;
      for (int i = 0; i < 8 + 300; i++) begin
         ADDR_IN = 24'(i);
         DATA_IN = 8'(i);
         step();
      end
      WRQ_IN = 1'b0;
      n_assert++;
      if (DROP_CNT !== 8'd255 || LEVEL !== 6'd8 || OVF !== 1'b1) begin
         n_fail++;
         $display("FAIL drop_saturate: DROP=%0d LEVEL=%0d OVF=%b required 255/8/1", DROP_CNT, LEVEL, OVF);
      end
   endtask

   task automatic test_reset_mid();
      int pulses;
      do_reset();
      BUS_RDY = 1'b0;
      for (int i = 0; i < 9; i++) push(24'(24'h600000 + i), 8'(i));
      BUS_RDY = 1'b1;
      step();
      step();
      BUS_RDY = 1'b0;
      step();
      BUS_RDY = 1'b1;
      #2 reset_n = 1'b0;
      model_reset();
      #1;
      n_assert++;
      if (BUS_WRQ !== 1'b0 || LEVEL !== 6'd0 || OVF !== 1'b0 || DROP_CNT !== 8'd0 ||
          ROM_ADDR !== 24'h000000 || ROM_DATA !== 8'h00) begin
         n_fail++;
         $display("FAIL reset_mid_outputs: BUS_WRQ=%b LEVEL=%0d OVF=%b DROP=%0d ROM=%h/%h required all zero",
                  BUS_WRQ, LEVEL, OVF, DROP_CNT, ROM_ADDR, ROM_DATA);
      end
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      pulses = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (BUS_WRQ === 1'b1) pulses++;
      end
      n_assert++;
      if (pulses != 0 || LEVEL !== 6'd0) begin
         n_fail++;
         $display("FAIL reset_mid_after: pulses=%0d LEVEL=%0d required 0/0", pulses, LEVEL);
      end
   endtask

   task automatic test_random();
      bit ok;
      do_reset();
      arb_auto = 1;
      for (int i = 0; i < 800; i++) begin
         WRQ_IN  = $urandom_range(0, 1);
         ADDR_IN = 24'($urandom);
         DATA_IN = 8'($urandom);
         FLUSH   = ($urandom_range(0, 39) == 0);
         step();
         n_assert++;
         if (LEVEL !== 6'(mq.size()) || OVF !== m_ovf || DROP_CNT !== 8'(m_drop)) begin
            n_fail++;
            $display("FAIL random_cycle%0d: LEVEL=%0d OVF=%b DROP=%0d required %0d/%0b/%0d",
                     i, LEVEL, OVF, DROP_CNT, mq.size(), m_ovf, m_drop);
         end
      end
      drain(200, ok);
      n_assert++;
      if (!ok || LEVEL !== 6'd0 || m_unexp != 0 || m_missed != 0 || m_romchg != 0 || got_q.size() != exp_q.size()) begin
         n_fail++;
         $display("FAIL random_scoreboard: done=%0d LEVEL=%0d unexp=%0d missed=%0d romchg=%0d issued=%0d required 1/0/0/0/0/%0d",
                  ok, LEVEL, m_unexp, m_missed, m_romchg, got_q.size(), exp_q.size());
      end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         n_assert++;
         if (got_q[i] !== exp_q[i]) begin
            n_fail++;
            $display("FAIL random_entry[%0d]: issued %h required %h", i, got_q[i], exp_q[i]);
         end
      end
   endtask

   initial begin
      model_reset();
      arb_auto = 0;
      test_reset();
      test_single_push();
      test_overflow();
      test_full_push_pop();
      test_wrap();
      test_flush_wait_ack();
      test_flush_idle();
      test_drop_sat();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
